// File: rtl/updown_count_decoder.sv
// Monitor for an up/down counter: recovers direction from the sampled count bus and
// flags wraps, reversals, stalls and illegal steps, with a saturating error tally.
module updown_count_decoder #(
    parameter int WIDTH       = 8,
    parameter int STALL_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             locked,
    output logic             wrap,
    output logic             dir_change,
    output logic             stall,
    output logic             step_err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]       STALL_TOP = 8'(STALL_LIMIT - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             dir_q, dir_d;
    logic             locked_q, locked_d;
    logic             wrap_q, wrap_d;
    logic             dir_change_q, dir_change_d;
    logic             stall_q, stall_d;
    logic             step_err_q, step_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [7:0]       stall_cnt_q, stall_cnt_d;

    logic [WIDTH-1:0] delta;
    logic             step_up, step_dn, step_zero, step_match;

    // Modular difference classifies the step; wrap cases fall out naturally as +/-1.
    always_comb begin
        delta      = count - prev_q;
        step_up    = (delta == ONE);
        step_dn    = (delta == ALL_ONES);
        step_zero  = (delta == ALL_ZERO);
        step_match = (step_up && !dir_q) || (step_dn && dir_q);
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = count;
        dir_d        = dir_q;
        wrap_d       = 1'b0;
        dir_change_d = 1'b0;
        stall_d      = 1'b0;
        step_err_d   = 1'b0;
        stall_cnt_d  = stall_cnt_q;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            S_INIT: begin
                state_d     = S_ACQ;
                stall_cnt_d = '0;
            end
            S_ACQ: begin
                stall_cnt_d = '0;
                if (step_up) begin
                    dir_d   = 1'b0;
                    state_d = S_LOCK;
                end else if (step_dn) begin
                    dir_d   = 1'b1;
                    state_d = S_LOCK;
                end else if (!step_zero) begin
                    step_err_d = 1'b1;
                end
            end
            S_LOCK: begin
                if (step_up || step_dn) begin
                    stall_cnt_d = '0;
                    if (step_match) begin
                        wrap_d = step_up ? (prev_q == ALL_ONES) : (prev_q == ALL_ZERO);
                    end else begin
                        dir_d        = ~dir_q;
                        dir_change_d = 1'b1;
                    end
                end else if (step_zero) begin
                    if (stall_cnt_q == STALL_TOP) begin
                        stall_d     = 1'b1;
                        stall_cnt_d = '0;
                        state_d     = S_ACQ;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                    end
                end else begin
                    step_err_d  = 1'b1;
                    stall_cnt_d = '0;
                    state_d     = S_ACQ;
                end
            end
            default: begin
                state_d     = S_INIT;
                stall_cnt_d = '0;
            end
        endcase

        if (step_err_d && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;

        locked_d = (state_d == S_LOCK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_INIT;
            prev_q       <= '0;
            dir_q        <= 1'b0;
            locked_q     <= 1'b0;
            wrap_q       <= 1'b0;
            dir_change_q <= 1'b0;
            stall_q      <= 1'b0;
            step_err_q   <= 1'b0;
            err_cnt_q    <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            dir_q        <= dir_d;
            locked_q     <= locked_d;
            wrap_q       <= wrap_d;
            dir_change_q <= dir_change_d;
            stall_q      <= stall_d;
            step_err_q   <= step_err_d;
            err_cnt_q    <= err_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign dir        = dir_q;
    assign locked     = locked_q;
    assign wrap       = wrap_q;
    assign dir_change = dir_change_q;
    assign stall      = stall_q;
    assign step_err   = step_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: doc/updown_count_decoder.md
# updown_count_decoder

Receive-side companion to the synchronous up/down counter. Samples the counter's `count` bus every clock and recovers the direction that drove it, using the same `in` encoding: 0 = up, 1 = down. Flags wrap-around, direction reversals, stalls and illegal steps, and keeps a saturating error tally. Sits beside the counter in checker/monitor position; it has no effect on the counter.

## Interface
- `WIDTH`, 8, width of the observed count bus.
- `STALL_LIMIT`, 4, number of consecutive unchanged samples in LOCK that drops lock; legal range 1..255.
- `clk`  input  1  rising-edge clock, shared with the counter.
- `rst`  input  1  asynchronous, active-low reset.
- `count`  input  WIDTH  observed counter value, sampled every rising edge.
- `dir`  output  1  recovered direction: 0 = up, 1 = down.
- `locked`  output  1  high while a consistent ±1 stepping stream is being tracked.
- `wrap`  output  1  one-cycle pulse on a legal wrap: all-ones→0 while up, or 0→all-ones while down.
- `dir_change`  output  1  one-cycle pulse when a locked stream reverses direction.
- `stall`  output  1  one-cycle pulse when the stall limit is reached.
- `step_err`  output  1  one-cycle pulse on an illegal step.
- `err_cnt`  output  8  saturating count of `step_err` pulses since reset.

## Operation
- Step arithmetic: `delta = count − prev`, modulo 2^WIDTH, where `prev` is the registered previous sample. Classes:
  - +1: `delta == 1`.
  - −1: `delta` all ones.
  - zero: `delta == 0`.
  - illegal: anything else.
- `prev <= count` on every clock edge in every state after reset.
- States:
  - INIT: capture `count` into `prev`; go to ACQ unconditionally.
  - ACQ:
    - +1: `dir <= 0`, go to LOCK.
    - −1: `dir <= 1`, go to LOCK.
    - zero: stay in ACQ.
    - illegal: pulse `step_err`, stay in ACQ.
  - LOCK:
    - Step matching `dir`: stay in LOCK, clear the stall counter.
    - ±1 step opposite to `dir`: toggle `dir`, pulse `dir_change`, stay in LOCK, clear the stall counter.
    - zero: increment the stall counter. When it reaches `STALL_LIMIT`, pulse `stall`, clear the counter, go to ACQ. `dir` holds its last value.
    - illegal: pulse `step_err`, go to ACQ, clear the stall counter.
- `wrap` pulses only on the LOCK transitions that match `dir`:
  - up, `prev` all ones → `count` 0;
  - down, `prev` 0 → `count` all ones.
- A reversal across the wrap boundary (e.g. 0→all-ones while `dir`=0) pulses `dir_change` only; `wrap` stays low.
- `locked` = (state == LOCK), registered.
- `err_cnt` increments on every `step_err` and saturates at 255.
- Simultaneous events: `dir_change` and `wrap` are mutually exclusive by construction. `stall` and `step_err` cannot coincide.
- Reset mid-operation: asserting `rst` low at any time immediately forces the reset values below and state INIT, independent of `clk`.

## Timing
- Reset values: state INIT, `prev` 0, `dir` 0, `locked` 0, all pulses 0, `err_cnt` 0, stall counter 0.
- All outputs are registered. The decision comparing the sample at edge k with the sample at edge k−1 is visible immediately after edge k.
- The first edge after reset release performs INIT, and that edge produces no decision.
- Lock latency:
  - INIT at edge 1, `locked` high after edge 2, given a ±1 step between edges 1 and 2;
  - minimum of 2 edges from reset release.
- Pulses are exactly one cycle wide. Repeated events produce back-to-back pulses.
- Stall: `STALL_LIMIT` consecutive zero deltas drop `locked` after the `STALL_LIMIT`-th unchanged edge. With the counter sampled at full rate, a stall means the counter is frozen (held in reset or otherwise stopped).

## Test plan
- Reset then up count, `count` 0,1,2,… → `locked` high after the 2nd edge, `dir` = 0, no pulses, `err_cnt` = 0.
- Up count 253→254→255→0→1 → single `wrap` pulse on the 255→0 edge; `locked` stays high.
- Up run to 20, then 19,18,… → `dir_change` pulse on the 20→19 edge, `dir` = 1 from then on. Later 0→255 while down → `wrap` pulse, no `dir_change`.
- Hold `count` at 7 for 4 edges while locked (`STALL_LIMIT`=4) → `stall` pulse on the 4th edge, `locked` falls, `dir` held. Resuming with 8 → relock with `dir` = 0 one edge later.
- Jump 10→50 while locked → `step_err` pulse, `locked` low, `err_cnt` = 1. Then 51 → relock. Forcing 300 illegal jumps → `err_cnt` saturates at 255.
- Assert `rst` low mid-stream, between clock edges → all outputs 0 immediately. Release → INIT then ACQ sequence as in the first scenario.
